// File: rtl/time_pkg.sv
// Shared encodings and constants for the time-of-day counter.
// The set-mode encoding is visible on the set_mode output.
package time_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_HOUR = 2'b01,
        MODE_SET_MIN  = 2'b10
    } set_mode_e;

    localparam logic [7:0] SEC_MAX = 8'h59;
    localparam logic [7:0] MIN_MAX = 8'h59;

    // Packs a small binary value (0..99) into two BCD digits.
    function automatic logic [7:0] bin_to_bcd(input int value);
        return {4'(value / 10), 4'(value % 10)};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter that wraps MOD-1 -> 00.
// carry flags the increment that causes the wrap, so counters can be chained.
module bcd_mod_counter
    import time_pkg::*;
#(
    parameter int MOD = 60
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       inc,
    input  logic       clear,
    output logic [7:0] bcd,
    output logic       carry
);

    localparam logic [7:0] LAST = bin_to_bcd(MOD - 1);

    logic [7:0] bcd_q;
    logic [7:0] bcd_d;

    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
        bcd_d = bcd_q;
        if (clear) begin
            bcd_d = 8'h00;
        end else if (inc) begin
            if (bcd_q >= LAST) begin
                bcd_d = 8'h00;
            end else if (bcd_q[3:0] >= 4'd9) begin
                bcd_d = {bcd_q[7:4] + 4'd1, 4'd0};
            end else begin
                bcd_d = {bcd_q[7:4], bcd_q[3:0] + 4'd1};
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            bcd_q <= 8'h00;
        end else begin
            bcd_q <= bcd_d;
        end
    end

    assign bcd   = bcd_q;
    assign carry = inc && (bcd_q == LAST);

endmodule

// File: rtl/time_keeper.sv
// Time-of-day counter: syncs the 1 Hz tick and buttons, detects rising edges,
// and runs a RUN / SET_HOUR / SET_MIN state machine over three chained BCD counters.
module time_keeper
    import time_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOUR_MOD    = 24
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] set_mode,
    output logic       sec_pulse
);

    localparam int TICK = 0;
    localparam int MODE = 1;
    localparam int INC  = 2;

    logic [2:0] sync_q [SYNC_STAGES];
    logic [2:0] delay_q;
    logic [2:0] edge_q;

    // NOTE: the sync chain is a small flop array, so it is reset like any other state.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b000;
            delay_q <= 3'b000;
            edge_q  <= 3'b000;
        end else begin
            sync_q[0] <= {btn_inc, btn_mode, tick_1hz};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            delay_q <= sync_q[SYNC_STAGES-1];
            edge_q  <= sync_q[SYNC_STAGES-1] & ~delay_q;
        end
    end

    logic tick_press, mode_press, inc_press;
    assign tick_press = edge_q[TICK];
    assign mode_press = edge_q[MODE];
    assign inc_press  = edge_q[INC];

    set_mode_e state_q;
    logic      sec_pulse_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= MODE_RUN;
            sec_pulse_q <= 1'b0;
        end else begin
            sec_pulse_q <= tick_press;
            case (state_q)
                MODE_RUN:      if (mode_press) state_q <= MODE_SET_HOUR;
                MODE_SET_HOUR: if (mode_press) state_q <= MODE_SET_MIN;
                MODE_SET_MIN:  if (mode_press) state_q <= MODE_RUN;
                default:       state_q <= MODE_RUN;
            endcase
        end
    end

    logic in_run, in_set_hour, in_set_min;
    logic sec_inc, sec_clr, min_inc, hour_inc;
    logic sec_carry, min_carry, hour_carry_unused;

    assign in_run      = (state_q == MODE_RUN);
    assign in_set_hour = (state_q == MODE_SET_HOUR);
    assign in_set_min  = (state_q == MODE_SET_MIN);

    // Mode press takes priority: an inc arriving with it is dropped.
    assign sec_inc  = tick_press & in_run;
    assign sec_clr  = mode_press & in_set_min;
    assign min_inc  = (sec_carry & in_run) | (inc_press & ~mode_press & in_set_min);
    assign hour_inc = (min_carry & in_run) | (inc_press & ~mode_press & in_set_hour);

    bcd_mod_counter #(.MOD(60)) u_sec (
        .clk   (clk),
        .clr_n (clr_n),
        .inc   (sec_inc),
        .clear (sec_clr),
        .bcd   (sec_bcd),
        .carry (sec_carry)
    );

    bcd_mod_counter #(.MOD(60)) u_min (
        .clk   (clk),
        .clr_n (clr_n),
        .inc   (min_inc),
        .clear (1'b0),
        .bcd   (min_bcd),
        .carry (min_carry)
    );

    bcd_mod_counter #(.MOD(HOUR_MOD)) u_hour (
        .clk   (clk),
        .clr_n (clr_n),
        .inc   (hour_inc),
        .clear (1'b0),
        .bcd   (hour_bcd),
        .carry (hour_carry_unused)
    );

    assign set_mode  = state_q;
    assign sec_pulse = sec_pulse_q;

endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench: two instances (24 h and 12 h) share stimulus; a seconds-based
// model predicts the time shown at every sec_pulse, and a monitor compares it.
module tb_time_keeper;
    import time_pkg::*;

    localparam int S   = 2;
    localparam int GAP = S + 3;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    logic tick = 1'b0, bm = 1'b0, bi = 1'b0;
    logic [7:0] h0, m0, s0, h1, m1, s1;
    logic [1:0] md0, md1;
    logic       p0, p1;

    always #5 clk = ~clk;

    time_keeper #(.SYNC_STAGES(S), .HOUR_MOD(24)) dut24 (
        .clk(clk), .clr_n(clr_n), .tick_1hz(tick), .btn_mode(bm), .btn_inc(bi),
        .hour_bcd(h0), .min_bcd(m0), .sec_bcd(s0), .set_mode(md0), .sec_pulse(p0)
    );

    time_keeper #(.SYNC_STAGES(S), .HOUR_MOD(12)) dut12 (
        .clk(clk), .clr_n(clr_n), .tick_1hz(tick), .btn_mode(bm), .btn_inc(bi),
        .hour_bcd(h1), .min_bcd(m1), .sec_bcd(s1), .set_mode(md1), .sec_pulse(p1)
    );

    typedef struct packed {
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic [1:0] md;
    } snap_t;

    int    passed = 0;
    int    total  = 0;
    int    pulses = 0;
    int    secs_m [2];
    int    hm     [2] = '{24, 12};
    int    mode_m = 0;
    snap_t q0 [$];
    snap_t q1 [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic snap_t expect_snap(input int k);
        snap_t r;
        r.h  = bcd(secs_m[k] / 3600);
        r.m  = bcd((secs_m[k] / 60) % 60);
        r.s  = bcd(secs_m[k] % 60);
        r.md = 2'(mode_m);
        return r;
    endfunction

    // Reference behaviour expressed as wall-clock arithmetic on seconds-of-day.
    task automatic model_event(input bit t, input bit m, input bit i);
        for (int k = 0; k < 2; k++) begin
            if (t && mode_m == 0) secs_m[k] = (secs_m[k] + 1) % (hm[k] * 3600);
        end
        if (m) begin
            if (mode_m == 2) for (int k = 0; k < 2; k++) secs_m[k] -= secs_m[k] % 60;
            mode_m = (mode_m + 1) % 3;
        end else if (i) begin
            for (int k = 0; k < 2; k++) begin
                int hh, mm, ss;
                hh = secs_m[k] / 3600;
                mm = (secs_m[k] / 60) % 60;
                ss = secs_m[k] % 60;
                if (mode_m == 1) hh = (hh + 1) % hm[k];
                if (mode_m == 2) mm = (mm + 1) % 60;
                secs_m[k] = hh * 3600 + mm * 60 + ss;
            end
        end
        if (t) begin
            q0.push_back(expect_snap(0));
            q1.push_back(expect_snap(1));
        end
    endtask

    task automatic do_event(input bit t, input bit m, input bit i);
        @(negedge clk);
        tick = t; bm = m; bi = i;
        model_event(t, m, i);
        repeat (GAP) @(negedge clk);
        tick = 1'b0; bm = 1'b0; bi = 1'b0;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic check_now(input string name);
        check({name, "_24h"}, 32'({h0, m0, s0, md0}), 32'(expect_snap(0)));
        check({name, "_12h"}, 32'({h1, m1, s1, md1}), 32'(expect_snap(1)));
    endtask

    // Monitor: every strobe must match the oldest outstanding prediction.
    always @(negedge clk) begin
        if (clr_n) begin
            if (p0) begin
                pulses++;
                if (q0.size() == 0) begin
                    total++;
                    $display("FAIL sb24_pulse: got strobe with time %h expected none", {h0, m0, s0});
                end else check("sb24_pulse", 32'({h0, m0, s0, md0}), 32'(q0.pop_front()));
            end
            if (p1) begin
                if (q1.size() == 0) begin
                    total++;
                    $display("FAIL sb12_pulse: got strobe with time %h expected none", {h1, m1, s1});
                end else check("sb12_pulse", 32'({h1, m1, s1, md1}), 32'(q1.pop_front()));
            end
        end
    end

    initial begin
        int p_before;
        secs_m[0] = 0;
        secs_m[1] = 0;

        repeat (3) @(negedge clk);
        check("reset_state", 32'({h0, m0, s0, md0, p0}), 32'd0);
        clr_n = 1'b1;
        repeat (2) @(negedge clk);

        // First tick: strobe exactly on edge S+1 after the first sampling edge.
        tick = 1'b1;
        model_event(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("latency_pulse_%0d", k), 32'(p0), 32'(k == S + 1));
            check($sformatf("latency_sec_%0d", k), 32'(s0), (k >= S + 1) ? 32'h01 : 32'h00);
        end
        tick = 1'b0;
        repeat (GAP) @(negedge clk);

        // Asynchronous reset mid-cycle, with a tick edge still in the sync chain.
        do_event(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #2 clr_n = 1'b0;
        #1 check("async_reset", 32'({h0, m0, s0, md0, p0}), 32'd0);
        secs_m[0] = 0;
        secs_m[1] = 0;
        mode_m = 0;
        q0.delete();
        q1.delete();
        tick = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        repeat (10) @(negedge clk);
        check_now("after_reset");

        // Set hour: 25 presses wrap the 24 h field to 01; a long hold counts once.
        repeat (3) do_event(1'b1, 1'b0, 1'b0);
        do_event(1'b0, 1'b1, 1'b0);
        repeat (25) do_event(1'b0, 1'b0, 1'b1);
        check("hour_after_25", 32'(h0), 32'h01);
        @(negedge clk);
        bi = 1'b1;
        repeat (100) @(negedge clk);
        bi = 1'b0;
        model_event(1'b0, 1'b0, 1'b1);
        repeat (GAP) @(negedge clk);
        check_now("hold_inc");

        // Seconds frozen while setting, but every tick still strobes.
        p_before = pulses;
        repeat (5) do_event(1'b1, 1'b0, 1'b0);
        check("freeze_pulses", 32'(pulses - p_before), 32'd5);
        check("freeze_sec", 32'(s0), 32'h03);

        // Mode and inc together: mode wins, hour unchanged.
        do_event(1'b0, 1'b1, 1'b1);
        check_now("mode_beats_inc");
        repeat (61) do_event(1'b0, 1'b0, 1'b1);
        check("min_after_61", 32'({h0, m0}), 32'h0201);
        do_event(1'b0, 1'b1, 1'b0);
        check_now("exit_set_clears_sec");

        // Preload 23:59:59 (11:59:59 on the 12 h copy) and roll over.
        do_event(1'b0, 1'b1, 1'b0);
        repeat (21) do_event(1'b0, 1'b0, 1'b1);
        do_event(1'b0, 1'b1, 1'b0);
        repeat (58) do_event(1'b0, 1'b0, 1'b1);
        do_event(1'b0, 1'b1, 1'b0);
        repeat (59) do_event(1'b1, 1'b0, 1'b0);
        check("preload_24h", 32'({h0, m0, s0}), 32'h235959);
        check("preload_12h", 32'({h1, m1, s1}), 32'h115959);
        do_event(1'b1, 1'b0, 1'b0);
        check("rollover_24h", 32'({h0, m0, s0}), 32'h000000);
        check("rollover_12h", 32'({h1, m1, s1}), 32'h000000);

        // Tick and mode together in RUN: tick counts, state advances.
        do_event(1'b1, 1'b1, 1'b0);
        check("tick_and_mode", 32'({s0, md0}), 32'({8'h01, 2'b01}));

        // Illegal state recovers to RUN with time untouched.
        @(negedge clk);
        force dut24.state_q = set_mode_e'(2'b11);
        force dut12.state_q = set_mode_e'(2'b11);
        @(negedge clk);
        release dut24.state_q;
        release dut12.state_q;
        mode_m = 0;
        @(negedge clk);
        check_now("illegal_recovers");

        // Randomized traffic against the model.
        for (int n = 0; n < 150; n++) begin
            do_event($urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0,
                     $urandom_range(0, 2) == 0);
            if (n % 15 == 14) check_now($sformatf("random_%0d", n));
        end

        repeat (10) @(negedge clk);
        check("drain24", 32'(q0.size()), 32'd0);
        check("drain12", 32'(q1.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
